// File: rtl/rb.sv
// rtl/rb.sv - read-back unit: fetches 4-word groups from the result RAM and presents them on MU1..MU4
//
// Purpose: on a start request, issue N_WORDS consecutive reads to the single-port
// result RAM at the auto-incrementing read pointer, collect the returned words and
// hold them in parallel behind a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdb               start request (IDLE, or HOLD during the completing handshake)
//   ptr_clr           read-pointer clear, honoured only in IDLE
//   dataRAM_in        RAM read data, one cycle after the address
//   re_n, r_addr      RAM read enable (active low) and address
//   MU1..MU4          words from group address +0..+3
//   valid, ready      group handshake
//   busy              high whenever not IDLE

`timescale 1ns/1ps

module rb #(
    parameter int PTR_W   = 6,
    parameter int DATA_W  = 18,
    parameter int N_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdb,
    input  logic              ptr_clr,
    input  logic [31:0]       dataRAM_in,
    output logic              re_n,
    output logic [7:0]        r_addr,
    output logic [DATA_W-1:0] MU1,
    output logic [DATA_W-1:0] MU2,
    output logic [DATA_W-1:0] MU3,
    output logic [DATA_W-1:0] MU4,
    output logic              valid,
    input  logic              ready,
    output logic              busy
);

    localparam int               IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LAST = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    // Capture lags issue by one cycle to match the RAM read latency.
    logic              cap_q;
    logic [IDX_W-1:0]  cap_idx_q;
    logic [DATA_W-1:0] mu_q [N_WORDS];

    logic              unused_hi;
    assign unused_hi = ^dataRAM_in[31:DATA_W];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rdb) state_d = S_READ;
            S_READ: if (idx_q == IDX_LAST) state_d = S_LAST;
            S_LAST: state_d = S_HOLD;
            S_HOLD: if (ready) state_d = rdb ? S_READ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        re_n   = (state_q != S_READ);
        valid  = (state_q == S_HOLD);
        busy   = (state_q != S_IDLE);
        r_addr = 8'(ptr_q);
    end

    // Pointer and issue-index next values
    always_comb begin
        ptr_d = ptr_q;
        idx_d = idx_q;
        case (state_q)
            S_IDLE: begin
                // Clear lands before the first READ cycle, so a simultaneous
                // start reads from address 0.
                if (ptr_clr) ptr_d = '0;
                if (rdb)     idx_d = '0;
            end
            S_READ: begin
                ptr_d = ptr_q + PTR_W'(1);
                idx_d = idx_q + IDX_W'(1);
            end
            S_HOLD: begin
                if (ready && rdb) idx_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                mu_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cap_q     <= (state_q == S_READ);
            cap_idx_q <= idx_q;
            if (cap_q) begin
                mu_q[cap_idx_q] <= dataRAM_in[DATA_W-1:0];
            end
        end
    end

    assign MU1 = mu_q[0];
    assign MU2 = mu_q[1];
    assign MU3 = mu_q[2];
    assign MU4 = mu_q[3];

endmodule

// File: tb/tb_rb.sv
// tb/tb_rb.sv - scoreboard testbench for rb

`timescale 1ns/1ps

module tb_rb;

    logic        clk;
    logic        rst;
    logic        rdb;
    logic        ptr_clr;
    logic [31:0] dataRAM_in;
    logic        re_n;
    logic [7:0]  r_addr;
    logic [17:0] MU1, MU2, MU3, MU4;
    logic        valid;
    logic        ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [7:0]  aq [$];
    logic [71:0] gq [$];
    int          mptr = 0;

    rb dut (
        .clk        (clk),
        .rst        (rst),
        .rdb        (rdb),
        .ptr_clr    (ptr_clr),
        .dataRAM_in (dataRAM_in),
        .re_n       (re_n),
        .r_addr     (r_addr),
        .MU1        (MU1),
        .MU2        (MU2),
        .MU3        (MU3),
        .MU4        (MU4),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, data one cycle after the address.
    always @(posedge clk) begin
        if (!re_n) dataRAM_in <= mem[r_addr];
    end

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: addresses and delivered groups are compared against the queues.
    always @(negedge clk) begin
        logic [7:0]  ea;
        logic [71:0] eg;
        if (re_n === 1'b0) begin
            if (aq.size() == 0) begin
                chk("addr_unexpected", {64'd0, r_addr}, 72'hFFFF);
            end else begin
                ea = aq.pop_front();
                chk("r_addr", {64'd0, r_addr}, {64'd0, ea});
            end
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            if (gq.size() == 0) begin
                chk("group_unexpected", {MU4, MU3, MU2, MU1}, '1);
            end else begin
                eg = gq.pop_front();
                chk("group", {MU4, MU3, MU2, MU1}, eg);
            end
        end
    end

    // Start a group; the model decides the addresses from its own pointer.
    task automatic issue(input bit clr, input bit from_idle);
        logic [71:0] g;
        logic [7:0]  a;
        if (clr && from_idle) mptr = 0;
        for (int k = 0; k < 4; k++) begin
            a = 8'(mptr);
            aq.push_back(a);
            g[k*18 +: 18] = mem[a][17:0];
            mptr = (mptr + 1) % 64;
        end
        gq.push_back(g);
        rdb     = 1'b1;
        ptr_clr = clr;
        @(posedge clk); #1;
        rdb     = 1'b0;
        ptr_clr = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (valid !== 1'b1) chk("wait_valid_timeout", {71'd0, valid}, 72'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", {71'd0, busy}, 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ren_cnt, v_cnt, first_v;
        logic [71:0] snap;
        bit          inflight;

        clk = 0; rst = 1; rdb = 0; ptr_clr = 0; ready = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h5A5C0011;
        mem[1] = 32'h00000022;
        mem[2] = 32'hFFF00033;
        mem[3] = 32'h0003FFFF;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_re_n",  {71'd0, re_n}, 72'd1);
        chk("rst_valid", {71'd0, valid}, 72'd0);
        chk("rst_busy",  {71'd0, busy}, 72'd0);
        chk("rst_addr",  {64'd0, r_addr}, 72'd0);
        chk("rst_mu",    {MU4, MU3, MU2, MU1}, 72'd0);

        // First group: latency and read-enable window.
        @(posedge clk); #1;
        ready = 1;
        issue(0, 1);
        ren_cnt = 0; v_cnt = 0; first_v = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (re_n === 1'b0) ren_cnt++;
            if (valid === 1'b1) begin
                v_cnt++;
                if (first_v == 0) first_v = i;
            end
        end
        chk("ren_cycles",  72'(ren_cnt), 72'd4);
        chk("valid_cycles", 72'(v_cnt), 72'd1);
        chk("valid_latency", 72'(first_v), 72'd6);
        chk("mu_after_hs", {MU4, MU3, MU2, MU1}, {18'h3FFFF, 18'h00033, 18'h00022, 18'h00011});

        // Stall: ready low for 10 cycles with a group held.
        @(posedge clk); #1;
        ready = 0;
        issue(0, 1);
        wait_valid();
        snap = {MU4, MU3, MU2, MU1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", {71'd0, valid}, 72'd1);
            chk("stall_re_n",  {71'd0, re_n}, 72'd1);
            chk("stall_mu",    {MU4, MU3, MU2, MU1}, snap);
        end
        @(posedge clk); #1;
        ready = 1;
        @(posedge clk); #1;
        chk("stall_release_valid", {71'd0, valid}, 72'd0);
        chk("stall_release_busy",  {71'd0, busy}, 72'd0);

        // Back-to-back start during the completing handshake.
        issue(0, 1);
        wait_valid();
        issue(0, 0);
        @(negedge clk);
        chk("b2b_re_n", {71'd0, re_n}, 72'd0);
        chk("b2b_busy", {71'd0, busy}, 72'd1);
        wait_valid();
        @(posedge clk); #1;
        wait_idle();

        // ptr_clr ignored in READ and HOLD, honoured with rdb in IDLE.
        issue(0, 1);
        ptr_clr = 1;
        wait_valid();
        issue(1, 0);
        ptr_clr = 1;
        wait_valid();
        @(posedge clk); #1;
        ptr_clr = 0;
        wait_idle();
        issue(1, 1);
        wait_valid();
        @(posedge clk); #1;

        // Walk the whole pointer range and wrap 63 -> 0.
        wait_idle();
        issue(1, 1);
        wait_valid();
        for (int g = 0; g < 16; g++) begin
            issue(0, 0);
            wait_valid();
        end
        @(posedge clk); #1;
        wait_idle();

        // Reset in the cycle after the second address.
        issue(0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_re_n",  {71'd0, re_n}, 72'd1);
        chk("midrst_valid", {71'd0, valid}, 72'd0);
        chk("midrst_busy",  {71'd0, busy}, 72'd0);
        chk("midrst_mu",    {MU4, MU3, MU2, MU1}, 72'd0);
        chk("midrst_addr",  {64'd0, r_addr}, 72'd0);
        chk("midrst_aq_left", 72'(aq.size()), 72'd1);
        chk("midrst_gq_left", 72'(gq.size()), 72'd1);
        aq.delete();
        gq.delete();
        mptr = 0;
        @(posedge clk); #1;
        issue(0, 1);
        wait_valid();
        @(posedge clk); #1;

        // Randomized traffic: stalls, back-to-back starts, stray clears.
        inflight = 0;
        for (int g = 0; g < 24; g++) begin
            if (!inflight) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                issue($urandom_range(0, 3) == 0, 1);
            end
            ptr_clr = 1'($urandom_range(0, 1));
            ready = 0;
            wait_valid();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            ready = 1;
            if (g + 1 < 24 && $urandom_range(0, 1) == 1) begin
                issue(1'($urandom_range(0, 1)), 0);
                inflight = 1;
            end else begin
                @(posedge clk); #1;
                ptr_clr = 0;
                inflight = 0;
            end
        end
        ptr_clr = 0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("end_aq_empty", 72'(aq.size()), 72'd0);
        chk("end_gq_empty", 72'(gq.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
